// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receiver: parity mode, receiver FSM
// states and the clk-cycles-per-oversample-tick calculation.
package uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE,
    PARITY_ODD,
    PARITY_EVEN
  } parity_t;

  // Prefixed so the names do not clash with the PARITY/STOP parameters.
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT
  } state_t;

  function automatic int tick_cycles(input real freq, input real baud, input int os);
    return $rtoi(freq / (baud * os));
  endfunction

endpackage

// File: rtl/uart_receive_fifo_fifo.sv
// Synchronous FIFO with registered head word (dat) and valid (stb).
// Capacity is exactly DEPTH words; a push while full succeeds only alongside a pop.
module uart_receive_fifo_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdat,
  input  logic             pop,
  output logic [WIDTH-1:0] dat,
  output logic             stb,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp, rp, rp_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             wr, rd;
  logic [WIDTH-1:0] head_n;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = !stb;
  assign rd    = pop && stb;
  assign wr    = push && (!full || rd);

  always_comb begin
    rp_n   = rp + AW'(rd);
    cnt_n  = cnt + CW'(wr) - CW'(rd);
    // When the pop leaves nothing stored, the incoming word becomes the head.
    head_n = (cnt == CW'(rd)) ? wdat : mem[rp_n];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      stb <= 1'b0;
      dat <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      rp  <= rp_n;
      cnt <= cnt_n;
      stb <= (cnt_n != '0);
      if (cnt_n != '0) dat <= head_n;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= wdat;
  end

endmodule

// File: rtl/uart_receive_fifo.sv
// Oversampling UART receiver with majority-vote sampling and an output FIFO.
// Optional break detection is enabled by defining UART_BREAK_DETECT_EN.
module uart_receive_fifo
  import uart_pkg::*;
#(
  parameter real     BAUDRATE   = 96e2,
  parameter real     FREQUENCY  = 100e6,
  parameter int      WIDTH      = 8,
  parameter parity_t PARITY     = PARITY_NONE,
  parameter int      STOP       = 1,
  parameter int      OVERSAMPLE = 16,
  parameter int      DEPTH      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rxd,
  output logic [WIDTH-1:0] dat,
  output logic             stb,
  input  logic             rdy,
  output logic             err,
  output logic             ovr,
  output logic             brk
);
  localparam int TICK = tick_cycles(FREQUENCY, BAUDRATE, OVERSAMPLE);
  localparam int TW   = (TICK > 1) ? $clog2(TICK) : 1;
  localparam int SW   = $clog2(OVERSAMPLE);
  localparam int BW   = $clog2(WIDTH + 1);
  localparam logic [SW-1:0] S_LO  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_MID = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_HI  = SW'(OVERSAMPLE / 2 + 1);

  logic             s1, s2, s3, fall;
  state_t           state, state_n;
  logic [TW-1:0]    tcnt, tcnt_n;
  logic [SW-1:0]    scnt, scnt_n;
  logic [1:0]       smp, smp_n;
  logic [BW-1:0]    bcnt, bcnt_n;
  logic             snum, snum_n;
  logic [WIDTH-1:0] shf, shf_n;
  logic             par, par_n, perr, perr_n;
  logic             tick, maj, decide;
  logic             push, err_n, ovr_n;
  logic             full, empty, pop;
`ifdef UART_BREAK_DETECT_EN
  logic             one, one_n, brk_n, brk_r;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) {s1, s2, s3} <= 3'b111;
    else      {s1, s2, s3} <= {rxd, s1, s2};
  end

  assign fall   = s3 && !s2;
  assign tick   = (tcnt == TW'(TICK - 1));
  assign maj    = (smp[0] & smp[1]) | (smp[0] & s2) | (smp[1] & s2);
  assign decide = tick && (scnt == S_HI);

  always_comb begin
    state_n = state;
    tcnt_n  = tick ? '0 : tcnt + 1'b1;
    scnt_n  = scnt;
    if (tick) scnt_n = (scnt == SW'(OVERSAMPLE - 1)) ? '0 : scnt + 1'b1;
    smp_n   = smp;
    if (tick && (scnt == S_LO || scnt == S_MID)) smp_n = {smp[0], s2};
    bcnt_n  = bcnt;
    snum_n  = snum;
    shf_n   = shf;
    par_n   = par;
    perr_n  = perr;
    push    = 1'b0;
    err_n   = 1'b0;
`ifdef UART_BREAK_DETECT_EN
    one_n   = one;
    brk_n   = 1'b0;
`endif
    // Every decision happens on the third vote; scnt keeps running so the
    // next bit's votes land at the same phase.
    case (state)
      S_IDLE: begin
        if (fall) begin
          state_n = S_START;
          tcnt_n  = '0;
          scnt_n  = '0;
          bcnt_n  = '0;
          snum_n  = 1'b0;
          par_n   = 1'b0;
          perr_n  = 1'b0;
`ifdef UART_BREAK_DETECT_EN
          one_n   = 1'b0;
`endif
        end
      end
      S_START: begin
        if (decide) state_n = maj ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (decide) begin
          shf_n  = {maj, shf[WIDTH-1:1]};
          par_n  = par ^ maj;
          bcnt_n = bcnt + 1'b1;
`ifdef UART_BREAK_DETECT_EN
          one_n  = one | maj;
`endif
          if (bcnt == BW'(WIDTH - 1)) state_n = (PARITY != PARITY_NONE) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (decide) begin
          perr_n  = (PARITY == PARITY_ODD) ? !(par ^ maj) : (par ^ maj);
          state_n = S_STOP;
`ifdef UART_BREAK_DETECT_EN
          one_n   = one | maj;
`endif
        end
      end
      S_STOP: begin
        if (decide) begin
          if (!maj) begin
            state_n = S_WAIT;
`ifdef UART_BREAK_DETECT_EN
            if (one) err_n = 1'b1;
            else     brk_n = 1'b1;
`else
            err_n = 1'b1;
`endif
          end else if (snum == 1'(STOP - 1)) begin
            state_n = S_IDLE;
            if (perr) err_n = 1'b1;
            else      push  = 1'b1;
          end else begin
            snum_n = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (s2) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign pop   = rdy && !empty;
  assign ovr_n = push && full && !pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      tcnt  <= '0;
      scnt  <= '0;
      smp   <= 2'b11;
      bcnt  <= '0;
      snum  <= 1'b0;
      par   <= 1'b0;
      perr  <= 1'b0;
      err   <= 1'b0;
      ovr   <= 1'b0;
    end else begin
      state <= state_n;
      tcnt  <= tcnt_n;
      scnt  <= scnt_n;
      smp   <= smp_n;
      bcnt  <= bcnt_n;
      snum  <= snum_n;
      par   <= par_n;
      perr  <= perr_n;
      err   <= err_n;
      ovr   <= ovr_n;
    end
  end

  always_ff @(posedge clk) begin
    shf <= shf_n;
  end

`ifdef UART_BREAK_DETECT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      one   <= 1'b0;
      brk_r <= 1'b0;
    end else begin
      one   <= one_n;
      brk_r <= brk_n;
    end
  end
  assign brk = brk_r;
`else
  assign brk = 1'b0;
`endif

  uart_receive_fifo_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .wdat (shf),
    .pop  (pop),
    .dat  (dat),
    .stb  (stb),
    .full (full),
    .empty(empty)
  );

endmodule

// File: tb/tb_uart_receive_fifo.sv
// Directed bench for uart_receive_fifo: one no-parity and one even-parity instance,
// each fed its own serial line at 32 clk per bit.
module tb_uart_receive_fifo;
  import uart_pkg::*;

  localparam int BITCLK = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rxd_a = 1'b1, rxd_b = 1'b1;
  logic       rdy_a = 1'b0, rdy_b = 1'b0;
  logic [7:0] dat_a, dat_b;
  logic       stb_a, err_a, ovr_a, brk_a;
  logic       stb_b, err_b, ovr_b, brk_b;

  always #5 clk = ~clk;

  uart_receive_fifo #(
    .BAUDRATE(1e6), .FREQUENCY(32e6), .WIDTH(8), .PARITY(PARITY_NONE),
    .STOP(1), .OVERSAMPLE(16), .DEPTH(4)
  ) dut_a (
    .clk(clk), .rst(rst), .rxd(rxd_a), .dat(dat_a), .stb(stb_a),
    .rdy(rdy_a), .err(err_a), .ovr(ovr_a), .brk(brk_a)
  );

  uart_receive_fifo #(
    .BAUDRATE(1e6), .FREQUENCY(32e6), .WIDTH(8), .PARITY(PARITY_EVEN),
    .STOP(1), .OVERSAMPLE(16), .DEPTH(4)
  ) dut_b (
    .clk(clk), .rst(rst), .rxd(rxd_b), .dat(dat_b), .stb(stb_b),
    .rdy(rdy_b), .err(err_b), .ovr(ovr_b), .brk(brk_b)
  );

  int n_chk = 0, n_pass = 0;
  int nerr_a = 0, novr_a = 0, nbrk_a = 0;
  int nerr_b = 0, novr_b = 0, nbrk_b = 0;
  logic [7:0] qa[$], qb[$];

  always @(negedge clk) begin
    if (stb_a && rdy_a) qa.push_back(dat_a);
    if (stb_b && rdy_b) qb.push_back(dat_b);
    if (err_a) nerr_a++;
    if (ovr_a) novr_a++;
    if (brk_a) nbrk_a++;
    if (err_b) nerr_b++;
    if (ovr_b) novr_b++;
    if (brk_b) nbrk_b++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic drive(input int ln, input logic v);
    if (ln == 0) rxd_a = v;
    else         rxd_b = v;
    repeat (BITCLK) @(posedge clk);
  endtask

  task automatic idle(input int ln, input int nbits);
    for (int i = 0; i < nbits; i++) drive(ln, 1'b1);
  endtask

  task automatic frame(input int ln, input logic [7:0] d, input logic use_par,
                       input logic pb, input logic sb);
    drive(ln, 1'b0);
    for (int i = 0; i < 8; i++) drive(ln, d[i]);
    if (use_par) drive(ln, pb);
    drive(ln, sb);
  endtask

  task automatic set_rdy_a(input logic v);
    @(posedge clk);
    #1 rdy_a = v;
  endtask

  initial begin
    int e0, b0;
    // reset state
    #12;
    chk("rst_dat", dat_a, 8'h00);
    chk("rst_stb", stb_a, 1'b0);
    chk("rst_err", err_a, 1'b0);
    chk("rst_ovr", ovr_a, 1'b0);
    chk("rst_brk", brk_a, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    idle(0, 2);

    // three words streamed with rdy high
    set_rdy_a(1'b1);
    frame(0, 8'h8f, 1'b0, 1'b0, 1'b1); idle(0, 2);
    frame(0, 8'hf8, 1'b0, 1'b0, 1'b1); idle(0, 2);
    frame(0, 8'h77, 1'b0, 1'b0, 1'b1); idle(0, 2);
    chk("t1_cnt", qa.size(), 3);
    if (qa.size() == 3) begin
      chk("t1_w0", qa[0], 8'h8f);
      chk("t1_w1", qa[1], 8'hf8);
      chk("t1_w2", qa[2], 8'h77);
    end
    chk("t1_err", nerr_a, 0);
    chk("t1_ovr", novr_a, 0);

    // words held while rdy low, then drained in order
    qa.delete();
    set_rdy_a(1'b0);
    frame(0, 8'h55, 1'b0, 1'b0, 1'b1); idle(0, 2);
    frame(0, 8'haa, 1'b0, 1'b0, 1'b1); idle(0, 2);
    chk("t2_stb_held", stb_a, 1'b1);
    chk("t2_dat_held", dat_a, 8'h55);
    set_rdy_a(1'b1);
    repeat (10) @(posedge clk);
    chk("t2_cnt", qa.size(), 2);
    if (qa.size() == 2) begin
      chk("t2_w0", qa[0], 8'h55);
      chk("t2_w1", qa[1], 8'haa);
    end
    chk("t2_stb_empty", stb_a, 1'b0);

    // overflow on the fifth word with DEPTH=4
    qa.delete();
    set_rdy_a(1'b0);
    for (int i = 1; i <= 4; i++) begin
      frame(0, 8'(i), 1'b0, 1'b0, 1'b1); idle(0, 2);
    end
    chk("t3_ovr_before", novr_a, 0);
    frame(0, 8'h05, 1'b0, 1'b0, 1'b1); idle(0, 2);
    chk("t3_ovr_after", novr_a, 1);
    chk("t3_head", dat_a, 8'h01);
    set_rdy_a(1'b1);
    repeat (12) @(posedge clk);
    chk("t3_cnt", qa.size(), 4);
    for (int i = 0; i < 4 && i < qa.size(); i++) chk("t3_word", qa[i], 32'(i + 1));
    chk("t3_stb_empty", stb_a, 1'b0);
    chk("t3_err", nerr_a, 0);

    // even parity: bad parity bit discarded, good one accepted
    rdy_b = 1'b1;
    frame(1, 8'h03, 1'b1, 1'b1, 1'b1); idle(1, 2);
    chk("t4_err_bad", nerr_b, 1);
    chk("t4_nopush", qb.size(), 0);
    frame(1, 8'h03, 1'b1, 1'b0, 1'b1); idle(1, 2);
    chk("t4_cnt", qb.size(), 1);
    if (qb.size() == 1) chk("t4_word", qb[0], 8'h03);
    chk("t4_err_total", nerr_b, 1);
    chk("t4_ovr", novr_b, 0);

    // quarter-bit glitch is a false start
    qa.delete();
    e0 = nerr_a;
    @(posedge clk);
    #1 rxd_a = 1'b0;
    repeat (BITCLK / 4) @(posedge clk);
    #1 rxd_a = 1'b1;
    idle(0, 3);
    chk("t5_glitch_err", nerr_a - e0, 0);
    chk("t5_glitch_nostb", qa.size(), 0);

    // zero stop bit: framing error, no word while the line stays low
    frame(0, 8'h3c, 1'b0, 1'b0, 1'b0);
    drive(0, 1'b0); drive(0, 1'b0);
    chk("t5_frame_err", nerr_a - e0, 1);
    chk("t5_frame_nostb", stb_a, 1'b0);
    idle(0, 2);
    frame(0, 8'h12, 1'b0, 1'b0, 1'b1); idle(0, 2);
    chk("t5_recover_cnt", qa.size(), 1);
    if (qa.size() == 1) chk("t5_recover_word", qa[0], 8'h12);
    chk("t5_err_total", nerr_a - e0, 1);

    // line held low for two frame times
    qa.delete();
    e0 = nerr_a;
    b0 = nbrk_a;
    for (int i = 0; i < 20; i++) drive(0, 1'b0);
    idle(0, 3);
`ifdef UART_BREAK_DETECT_EN
    chk("t6_brk", nbrk_a - b0, 1);
    chk("t6_err", nerr_a - e0, 0);
`else
    chk("t6_brk", nbrk_a - b0, 0);
    chk("t6_err", nerr_a - e0, 1);
`endif
    chk("t6_nostb", qa.size(), 0);

    // reset mid-frame with a word pending
    set_rdy_a(1'b0);
    frame(0, 8'h11, 1'b0, 1'b0, 1'b1); idle(0, 2);
    chk("t7_pending_stb", stb_a, 1'b1);
    chk("t7_pending_dat", dat_a, 8'h11);
    drive(0, 1'b0); drive(0, 1'b1); drive(0, 1'b0); drive(0, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("t7_rst_stb", stb_a, 1'b0);
    chk("t7_rst_dat", dat_a, 8'h00);
    chk("t7_rst_err", err_a, 1'b0);
    chk("t7_rst_ovr", ovr_a, 1'b0);
    rxd_a = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    idle(0, 2);
    qa.delete();
    set_rdy_a(1'b1);
    frame(0, 8'ha5, 1'b0, 1'b0, 1'b1); idle(0, 2);
    chk("t7_cnt", qa.size(), 1);
    if (qa.size() == 1) chk("t7_word", qa[0], 8'ha5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
